// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one bit per clock, shift-add multiply and restoring divide.
// Results, destination index and write enable feed the register file write port directly.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we
);

  typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic [4:0]          rd_q, rd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     oper_q, oper_d;
  logic                neg_q, neg_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_out_q, rd_out_d;

  logic                is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       add_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       rem_sh;
  logic [XLEN-1:0]     rem_sub;
  logic                rem_ge;
  logic [2*XLEN-1:0]   div_next;
  logic [2*XLEN-1:0]   prod_adj;
  logic [XLEN-1:0]     quo_adj, rem_adj, sel_res;

  // Operand classification at acceptance time
  always_comb begin
    is_div   = funct3[2];
    sgn_a    = is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    sgn_b    = is_div ? ~funct3[0] : (funct3 == 3'b001);
    a_neg    = sgn_a & op_a[XLEN-1];
    b_neg    = sgn_b & op_b[XLEN-1];
    mag_a    = a_neg ? (~op_a + XLEN'(1)) : op_a;
    mag_b    = b_neg ? (~op_b + XLEN'(1)) : op_b;
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special  = div_zero | div_ovf;
  end

  // Iteration datapath: acc holds {product hi, multiplier} or {remainder, quotient}
  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, oper_q} : {(XLEN+1){1'b0}});
    mul_next = {add_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    rem_sub  = rem_sh[XLEN-1:0] - oper_q;
    rem_ge   = rem_sh >= {1'b0, oper_q};
    div_next = rem_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                      : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Sign correction and result selection
  always_comb begin
    prod_adj = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    quo_adj  = neg_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    rem_adj  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + XLEN'(1)) : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:                 sel_res = prod_adj[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sel_res = prod_adj[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sel_res = quo_adj;
      default:                sel_res = rem_adj;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    oper_d   = oper_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          f3_d   = funct3;
          rd_d   = rd_in;
          cnt_d  = '0;
          busy_d = 1'b1;
          oper_d = is_div ? mag_b : mag_a;
          if (special) begin
            // Preload the final quotient/remainder so ADJ selects it unchanged
            state_d = ADJ;
            neg_d   = 1'b0;
            acc_d   = div_zero ? {op_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, op_a};
          end else begin
            state_d = CALC;
            neg_d   = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
            acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
          end
        end
      end
      CALC: begin
        acc_d = f3_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = ADJ;
      end
      ADJ: begin
        result_d = sel_res;
        rd_out_d = rd_q;
        done_d   = 1'b1;
        we_d     = (rd_q != 5'd0);
        state_d  = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      oper_q   <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      acc_q    <= acc_d;
      oper_q   <= oper_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign we     = we_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases, random ops against an
// arithmetic reference model, busy/start handling, rd=0 and asynchronous reset abort.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, we;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int vectors = 0;
  int miscompares = 0;

  mul_div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we(we)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ubs, p;
    longint unsigned ua, ub, up;
    logic [31:0] r;
    sa  = $signed(a);
    sb  = $signed(b);
    ubs = {32'b0, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    r   = '0;
    case (f3)
      3'd0: begin p = sa * sb;  r = p[31:0];  end
      3'd1: begin p = sa * sb;  r = p[63:32]; end
      3'd2: begin p = sa * ubs; r = p[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    logic [31:0] exp_r;
    int exp_lat, lat;
    bit seen;
    exp_r   = model(f3, a, b);
    exp_lat = is_special(f3, a, b) ? 1 : 33;
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
    vectors++;
    if (busy !== 1'b1) begin
      $display("FAIL %s busy after accept: got %b expected 1", tag, busy); miscompares++;
    end
    seen = 0; lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = n; seen = 1; break; end
    end
    vectors++;
    if (!seen) begin
      $display("FAIL %s timeout: no done within 60 cycles", tag); miscompares++;
    end else begin
      if (lat != exp_lat) begin
        $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat); miscompares++;
      end
      vectors++;
      if (result !== exp_r) begin
        $display("FAIL %s result: got %h expected %h", tag, result, exp_r); miscompares++;
      end
      vectors++;
      if (rd_out !== rd) begin
        $display("FAIL %s rd_out: got %0d expected %0d", tag, rd_out, rd); miscompares++;
      end
      vectors++;
      if (we !== (rd != 0)) begin
        $display("FAIL %s we: got %b expected %b", tag, we, (rd != 0)); miscompares++;
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || we !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL %s pulse end: got done=%b we=%b busy=%b expected 0 0 0", tag, done, we, busy);
        miscompares++;
      end
    end
    $display("op %-10s f3=%0d a=%h b=%h rd=%0d -> result=%h exp=%h lat=%0d", tag, f3, a, b, rd, result, exp_r, lat);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0) begin
      $display("FAIL reset state: got busy=%b done=%b we=%b result=%h rd_out=%0d expected all 0",
               busy, done, we, result, rd_out);
      miscompares++;
    end
    $display("op reset     busy=%b done=%b we=%b result=%h", busy, done, we, result);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  "mul");
    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd6,  "mulh");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  "mulhu");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  "mulhsu");
    run_op(3'd5, 32'd100,      32'd7,        5'd9,  "divu");
    run_op(3'd7, 32'd100,      32'd7,        5'd10, "remu");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        5'd11, "div_neg");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        5'd12, "rem_neg");
    run_op(3'd4, 32'd123,      32'd0,        5'd13, "div_zero");
    run_op(3'd6, 32'd123,      32'd0,        5'd14, "rem_zero");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, "rem_ovf");
    run_op(3'd0, 32'd0,        32'd12345,    5'd17, "mul_zero");
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), pick(), pick(), 5'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back_ignore();
    int dones, first;
    logic [31:0] exp_r;
    exp_r = model(3'd0, 32'd1234, 32'd5678);
    funct3 = 3'd0; op_a = 32'd1234; op_b = 32'd5678; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; first = 0;
    for (int n = 1; n <= 70; n++) begin
      if (n == 10) begin
        start = 1'b1; funct3 = 3'd4; op_a = 32'd5; op_b = 32'd0; rd_in = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        dones++;
        if (first == 0) first = n;
        vectors++;
        if (result !== exp_r || rd_out !== 5'd9) begin
          $display("FAIL busy_ignore result: got %h rd=%0d expected %h rd=9", result, rd_out, exp_r);
          miscompares++;
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (dones != 1 || first != 33) begin
      $display("FAIL busy_ignore dones: got %0d at cycle %0d expected 1 at cycle 33", dones, first);
      miscompares++;
    end
    $display("op busy_ign  dones=%0d first=%0d result=%h", dones, first, result);
  endtask

  task automatic test_rd_zero();
    run_op(3'd5, 32'd1000, 32'd10, 5'd0, "rd_zero");
  endtask

  task automatic test_async_reset();
    int dones;
    funct3 = 3'd0; op_a = $urandom; op_b = $urandom; rd_in = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || we !== 1'b0 || rd_out !== 5'd0) begin
      $display("FAIL async_reset: got busy=%b done=%b result=%h we=%b rd_out=%0d expected all 0",
               busy, done, result, we, rd_out);
      miscompares++;
    end
    $display("op async_rst busy=%b done=%b result=%h", busy, done, result);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || we === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      $display("FAIL abort no done: got %0d done cycles expected 0", dones); miscompares++;
    end
    run_op(3'd0, 32'd3, 32'd4, 5'd2, "mul_after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back_ignore();
    test_rd_zero();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
